fp_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 64 ++++++
 rtl/sigmoid_plan.sv | 43 ++++
 rtl/fp_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_fp_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared FSM encoding and fixed-point constants for the forward-propagation datapath.
// Constants are produced by helper functions so any WIDTH/FRAC pairing scales consistently.
package fp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHidMac,
    StHidAct,
    StOutMac,
    StOutAct,
    StDone
  } fp_state_e;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefFrac  = 24;

  // 1.0 and 0.5 at a given number of fractional bits
  function automatic logic [63:0] fx_one(input int unsigned frac);
    return 64'd1 << frac;
  endfunction

  function automatic logic [63:0] fx_half(input int unsigned frac);
    return 64'd1 << (frac - 1);
  endfunction

  // PLAN breakpoints: 5.0, 2.375 (19/8), 1.0
  function automatic logic [63:0] plan_bp_hi(input int unsigned frac);
    return 64'd5 << frac;
  endfunction

  function automatic logic [63:0] plan_bp_mid(input int unsigned frac);
    return 64'd19 << (frac - 3);
  endfunction

  function automatic logic [63:0] plan_bp_lo(input int unsigned frac);
    return 64'd1 << frac;
  endfunction

  // PLAN offsets: 0.84375 (27/32), 0.625 (5/8), 0.5
  function automatic logic [63:0] plan_off_hi(input int unsigned frac);
    return 64'd27 << (frac - 5);
  endfunction

  function automatic logic [63:0] plan_off_mid(input int unsigned frac);
    return 64'd5 << (frac - 3);
  endfunction

  function automatic logic [63:0] plan_off_lo(input int unsigned frac);
    return 64'd1 << (frac - 1);
  endfunction

  // Signed saturation limits; the caller truncates to its word width
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

  localparam logic [63:0] One  = fx_one(DefFrac);
  localparam logic [63:0] Half = fx_half(DefFrac);

endpackage

// File: rtl/sigmoid_plan.sv
// sigmoid_plan: combinational piecewise-linear sigmoid approximation using shifts only.
// Works on |x|, then mirrors as 1.0 - y for negative inputs.
module sigmoid_plan
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 24
) (
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] OneW   = WIDTH'(fx_one(FRAC));
  localparam logic [WIDTH-1:0] BpHi   = WIDTH'(plan_bp_hi(FRAC));
  localparam logic [WIDTH-1:0] BpMid  = WIDTH'(plan_bp_mid(FRAC));
  localparam logic [WIDTH-1:0] BpLo   = WIDTH'(plan_bp_lo(FRAC));
  localparam logic [WIDTH-1:0] OffHi  = WIDTH'(plan_off_hi(FRAC));
  localparam logic [WIDTH-1:0] OffMid = WIDTH'(plan_off_mid(FRAC));
  localparam logic [WIDTH-1:0] OffLo  = WIDTH'(plan_off_lo(FRAC));
  localparam logic [WIDTH-1:0] MinVal = WIDTH'(sat_min(WIDTH));

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] y_pos;
  logic             is_min;

  // Segment select on magnitude, then mirror for negative inputs
  always_comb begin
    is_min = (x == MinVal);
    a      = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    // Most-negative input has no positive magnitude; it saturates like a >= 5
    if (is_min || (a >= BpHi)) begin
      y_pos = OneW;
    end else if (a >= BpMid) begin
      y_pos = (a >> 5) + OffHi;
    end else if (a >= BpLo) begin
      y_pos = (a >> 3) + OffMid;
    end else begin
      y_pos = (a >> 2) + OffLo;
    end
    y = x[WIDTH-1] ? (OneW - y_pos) : y_pos;
  end

endmodule

// File: rtl/fp_seq.sv
// fp_seq: sequential forward propagation for a 2-layer ANN using one shared MAC and one
// PLAN sigmoid, evaluating one neuron at a time.
// Optional build macro FP_SAT_EN: accumulator saturates instead of wrapping on overflow.
module fp_seq
  import fp_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned N_HL_P = 3,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FRAC   = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [N_IN*WIDTH-1:0]           i_k,
  input  logic [N_HL_P*N_IN*WIDTH-1:0]    i_wght_hd,
  input  logic [N_HL_P*WIDTH-1:0]         i_bias_hd,
  input  logic [N_OUT*N_HL_P*WIDTH-1:0]   i_wght_o,
  input  logic [N_OUT*WIDTH-1:0]          i_bias_o,
  output logic [N_HL_P*WIDTH-1:0]         o_hd_a,
  output logic [N_OUT*WIDTH-1:0]          o_out_a,
  output logic                            o_busy,
  output logic                            o_valid
);

  localparam int unsigned Max01  = (N_IN > N_HL_P) ? N_IN : N_HL_P;
  localparam int unsigned CntMax = (Max01 > N_OUT) ? Max01 : N_OUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned PW     = 2 * WIDTH;

  fp_state_e state_q, state_d;

  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]         i_q, i_d;
  logic [CntW-1:0]         j_q, j_d;
  logic [N_HL_P*WIDTH-1:0] hd_q, hd_d;
  logic [N_OUT*WIDTH-1:0]  out_q, out_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;

  // Shadow copies so the caller may change inputs right after the accepting edge
  logic [N_IN*WIDTH-1:0]         k_q;
  logic [N_HL_P*N_IN*WIDTH-1:0]  whd_q;
  logic [N_HL_P*WIDTH-1:0]       bhd_q;
  logic [N_OUT*N_HL_P*WIDTH-1:0] wo_q;
  logic [N_OUT*WIDTH-1:0]        bo_q;

  logic signed [WIDTH-1:0] op_w, op_x;
  logic signed [PW-1:0]    prod;
  logic signed [WIDTH-1:0] term;
  logic signed [WIDTH-1:0] acc_sum;
  logic signed [WIDTH-1:0] sig_y;

  logic accept;
  assign accept = (state_q == StIdle) && i_start;

  sigmoid_plan #(
    .WIDTH(WIDTH),
    .FRAC (FRAC)
  ) u_sig (
    .x(acc_q),
    .y(sig_y)
  );

  // Capture the full operand set when a request is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q   <= '0;
      whd_q <= '0;
      bhd_q <= '0;
      wo_q  <= '0;
      bo_q  <= '0;
    end else if (accept) begin
      k_q   <= i_k;
      whd_q <= i_wght_hd;
      bhd_q <= i_bias_hd;
      wo_q  <= i_wght_o;
      bo_q  <= i_bias_o;
    end
  end

  // MAC operand select, truncated product and accumulate (wrap or saturate)
  always_comb begin
    op_w = '0;
    op_x = '0;
    if (state_q == StHidMac) begin
      op_w = whd_q[(int'(j_q) * int'(N_IN) + int'(i_q)) * int'(WIDTH) +: WIDTH];
      op_x = k_q[int'(i_q) * int'(WIDTH) +: WIDTH];
    end else if (state_q == StOutMac) begin
      op_w = wo_q[(int'(j_q) * int'(N_HL_P) + int'(i_q)) * int'(WIDTH) +: WIDTH];
      // Hidden activations of this run are already final when the output layer starts
      op_x = hd_q[int'(i_q) * int'(WIDTH) +: WIDTH];
    end
    prod = PW'(op_w) * PW'(op_x);
    term = WIDTH'(prod >>> FRAC);
  end

`ifdef FP_SAT_EN
  localparam logic [WIDTH-1:0] SatMax = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SatMin = WIDTH'(sat_min(WIDTH));
  logic [WIDTH:0] sum_ext;

  // Saturating accumulate: overflow when the two top bits of the extended sum differ
  always_comb begin
    sum_ext = {acc_q[WIDTH-1], acc_q} + {term[WIDTH-1], term};
    if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
      acc_sum = sum_ext[WIDTH] ? SatMin : SatMax;
    end else begin
      acc_sum = sum_ext[WIDTH-1:0];
    end
  end
`else
  // Wrapping accumulate modulo 2^WIDTH
  always_comb begin
    acc_sum = acc_q + term;
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    hd_d    = hd_q;
    out_d   = out_q;
    busy_d  = 1'b0;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          acc_d   = i_bias_hd[WIDTH-1:0];
          i_d     = '0;
          j_d     = '0;
          state_d = StHidMac;
        end
      end
      StHidMac: begin
        busy_d = 1'b1;
        acc_d  = acc_sum;
        if (int'(i_q) == int'(N_IN) - 1) begin
          i_d     = '0;
          state_d = StHidAct;
        end else begin
          i_d = i_q + CntW'(1);
        end
      end
      StHidAct: begin
        busy_d = 1'b1;
        hd_d[int'(j_q) * int'(WIDTH) +: WIDTH] = sig_y;
        if (int'(j_q) < int'(N_HL_P) - 1) begin
          j_d     = j_q + CntW'(1);
          acc_d   = bhd_q[(int'(j_q) + 1) * int'(WIDTH) +: WIDTH];
          state_d = StHidMac;
        end else begin
          j_d     = '0;
          acc_d   = bo_q[WIDTH-1:0];
          state_d = StOutMac;
        end
      end
      StOutMac: begin
        busy_d = 1'b1;
        acc_d  = acc_sum;
        if (int'(i_q) == int'(N_HL_P) - 1) begin
          i_d     = '0;
          state_d = StOutAct;
        end else begin
          i_d = i_q + CntW'(1);
        end
      end
      StOutAct: begin
        out_d[int'(j_q) * int'(WIDTH) +: WIDTH] = sig_y;
        if (int'(j_q) < int'(N_OUT) - 1) begin
          busy_d  = 1'b1;
          j_d     = j_q + CntW'(1);
          acc_d   = bo_q[(int'(j_q) + 1) * int'(WIDTH) +: WIDTH];
          state_d = StOutMac;
        end else begin
          j_d     = '0;
          valid_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      hd_q    <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      hd_q    <= hd_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign o_hd_a  = hd_q;
  assign o_out_a = out_q;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_fp_seq.sv
// tb_fp_seq: directed vectors for fp_seq, checked every cycle against an arithmetic model
// plus literal expectations for the hand-computed cases.
module tb_fp_seq;

  localparam int N_IN   = 2;
  localparam int N_HL_P = 3;
  localparam int N_OUT  = 2;
  localparam int W      = 32;
  localparam int FR     = 24;
  localparam int L      = N_HL_P * (N_IN + 1) + N_OUT * (N_HL_P + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_start = 1'b0;
  logic [N_IN*W-1:0]         i_k;
  logic [N_HL_P*N_IN*W-1:0]  i_wght_hd;
  logic [N_HL_P*W-1:0]       i_bias_hd;
  logic [N_OUT*N_HL_P*W-1:0] i_wght_o;
  logic [N_OUT*W-1:0]        i_bias_o;
  logic [N_HL_P*W-1:0]       o_hd_a;
  logic [N_OUT*W-1:0]        o_out_a;
  logic                      o_busy;
  logic                      o_valid;

  int n_chk = 0;
  int n_fail = 0;
  int t = -1;  // edges since accept; -1 when the model is idle
  logic [31:0] m_hd[N_HL_P];
  logic [31:0] m_out[N_OUT];
  logic [31:0] h_hd[N_HL_P];
  logic [31:0] h_out[N_OUT];

  fp_seq #(
    .N_IN  (N_IN),
    .N_HL_P(N_HL_P),
    .N_OUT (N_OUT),
    .WIDTH (W),
    .FRAC  (FR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_k      (i_k),
    .i_wght_hd(i_wght_hd),
    .i_bias_hd(i_bias_hd),
    .i_wght_o (i_wght_o),
    .i_bias_o (i_bias_o),
    .o_hd_a   (o_hd_a),
    .o_out_a  (o_out_a),
    .o_busy   (o_busy),
    .o_valid  (o_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint trunc_term(input longint p);
    logic [63:0] s;
    s = p >>> FR;
    return sx(s[31:0]);
  endfunction

  function automatic longint fold(input longint v);
`ifdef FP_SAT_EN
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
`else
    logic [63:0] u;
    u = v;
    return sx(u[31:0]);
`endif
  endfunction

  function automatic longint sig_ref(input longint x);
    longint one, a, y;
    one = 64'sd1 << FR;
    a = (x < 0) ? -x : x;
    if (a >= 5 * one) y = one;
    else if (8 * a >= 19 * one) y = a / 32 + (27 * one) / 32;
    else if (a >= one) y = a / 8 + (5 * one) / 8;
    else y = a / 4 + one / 2;
    return (x < 0) ? one - y : y;
  endfunction

  function automatic longint hid_ref(input int j);
    longint acc;
    acc = sx(i_bias_hd[j*W +: W]);
    for (int i = 0; i < N_IN; i++)
      acc = fold(acc + trunc_term(sx(i_wght_hd[(j*N_IN+i)*W +: W]) * sx(i_k[i*W +: W])));
    return sig_ref(acc);
  endfunction

  function automatic longint out_ref(input int k);
    longint acc;
    acc = sx(i_bias_o[k*W +: W]);
    for (int j = 0; j < N_HL_P; j++)
      acc = fold(acc + trunc_term(sx(i_wght_o[(k*N_HL_P+j)*W +: W]) * hid_ref(j)));
    return sig_ref(acc);
  endfunction

  // Model timeline: accept in idle, fixed latency, outputs held after completion
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t <= -1;
      for (int j = 0; j < N_HL_P; j++) h_hd[j] <= '0;
      for (int k = 0; k < N_OUT; k++) h_out[k] <= '0;
    end else if (t == L) begin
      t <= -1;
      for (int j = 0; j < N_HL_P; j++) h_hd[j] <= m_hd[j];
      for (int k = 0; k < N_OUT; k++) h_out[k] <= m_out[k];
    end else if (t >= 0) begin
      t <= t + 1;
    end else if (i_start) begin
      t <= 0;
      for (int j = 0; j < N_HL_P; j++) m_hd[j] <= 32'(hid_ref(j));
      for (int k = 0; k < N_OUT; k++) m_out[k] <= 32'(out_ref(k));
    end
  end

  // Compare process: handshake every cycle, data on valid and while idle
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 64'(o_busy), 64'(t >= 1 && t <= L - 1));
      check("valid", 64'(o_valid), 64'(t == L));
      if (t == L) begin
        for (int j = 0; j < N_HL_P; j++) check("model hd_a", 64'(o_hd_a[j*W +: W]), 64'(m_hd[j]));
        for (int k = 0; k < N_OUT; k++) check("model out_a", 64'(o_out_a[k*W +: W]), 64'(m_out[k]));
      end else if (t < 0) begin
        for (int j = 0; j < N_HL_P; j++) check("held hd_a", 64'(o_hd_a[j*W +: W]), 64'(h_hd[j]));
        for (int k = 0; k < N_OUT; k++) check("held out_a", 64'(o_out_a[k*W +: W]), 64'(h_out[k]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_uniform(input logic [31:0] k, input logic [31:0] whd, input logic [31:0] bhd,
                             input logic [31:0] wo, input logic [31:0] bo);
    for (int i = 0; i < N_IN; i++) i_k[i*W +: W] = k;
    for (int i = 0; i < N_HL_P * N_IN; i++) i_wght_hd[i*W +: W] = whd;
    for (int i = 0; i < N_HL_P; i++) i_bias_hd[i*W +: W] = bhd;
    for (int i = 0; i < N_OUT * N_HL_P; i++) i_wght_o[i*W +: W] = wo;
    for (int i = 0; i < N_OUT; i++) i_bias_o[i*W +: W] = bo;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_c);
    int c;
    bit got;
    c = 0;
    got = 1'b0;
    while (!got && c < 60) begin
      @(negedge clk);
      c++;
      if (o_valid) got = 1'b1;
    end
    check({name, " latency"}, 64'(c), 64'(exp_c));
  endtask

  task automatic expect_lanes(input string name, input logic [31:0] hd, input logic [31:0] outv);
    for (int j = 0; j < N_HL_P; j++) check({name, " hd_a"}, 64'(o_hd_a[j*W +: W]), 64'(hd));
    for (int k = 0; k < N_OUT; k++) check({name, " out_a"}, 64'(o_out_a[k*W +: W]), 64'(outv));
  endtask

  initial begin
    set_uniform(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 rst = 1'b1;
    #1;
    expect_lanes("reset", 32'h0, 32'h0);
    check("reset busy", 64'(o_busy), 64'd0);
    check("reset valid", 64'(o_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: all-zero parameters give sig(0) everywhere
    set_uniform(32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0);
    pulse_start();
    wait_valid("t1", L);
    expect_lanes("t1", 32'h0080_0000, 32'h0080_0000);
    check("t1 busy at valid", 64'(o_busy), 64'd0);

    // 2: hidden sum 1.0 -> 0.75, output sum -1.0 -> 0.25
    set_uniform(32'h0080_0000, 32'h0100_0000, 32'h0, 32'h0, 32'hFF00_0000);
    pulse_start();
    wait_valid("t2", L);
    expect_lanes("t2", 32'h00C0_0000, 32'h0040_0000);

    // 3: hidden sum 16 -> 1.0; output sum 3.0 -> 3/32 + 0.84375 = 0.9375
    set_uniform(32'h0800_0000, 32'h0100_0000, 32'h0, 32'h0100_0000, 32'h0);
    pulse_start();
    wait_valid("t3", L);
    expect_lanes("t3", 32'h0100_0000, 32'h00F0_0000);

    // 4: hidden accumulate overflows
    set_uniform(32'h7F00_0000, 32'h0100_0000, 32'h0, 32'h0, 32'h0);
    pulse_start();
    wait_valid("t4", L);
`ifdef FP_SAT_EN
    expect_lanes("t4 sat", 32'h0100_0000, 32'h0080_0000);
`else
    expect_lanes("t4 wrap", 32'h0020_0000, 32'h0080_0000);
`endif

    // Mixed-sign, per-lane distinct operands (model only)
    i_k[0 +: W] = 32'h0040_0000;
    i_k[W +: W] = 32'hFF80_0000;
    for (int j = 0; j < N_HL_P; j++) begin
      i_bias_hd[j*W +: W] = 32'((j - 1) * 32'sh0040_0000);
      for (int i = 0; i < N_IN; i++)
        i_wght_hd[(j*N_IN+i)*W +: W] = 32'((j + 1) * ((i == 0) ? 32'sh00C0_0000 : -32'sh0140_0000));
    end
    for (int k = 0; k < N_OUT; k++) begin
      i_bias_o[k*W +: W] = 32'(k * 32'sh0020_0000);
      for (int j = 0; j < N_HL_P; j++)
        i_wght_o[(k*N_HL_P+j)*W +: W] = 32'(((k == 0) ? 1 : -3) * (j + 1) * 32'sh0060_0000);
    end
    pulse_start();
    wait_valid("mixed", L);

    // 5: start during a run is ignored; inputs change after accept
    set_uniform(32'h0080_0000, 32'h0100_0000, 32'h0, 32'h0, 32'hFF00_0000);
    pulse_start();
    set_uniform(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_valid("t5", L - 5);
    expect_lanes("t5", 32'h00C0_0000, 32'h0040_0000);

    // 6: asynchronous reset mid-run clears everything, then a clean run
    set_uniform(32'h0800_0000, 32'h0100_0000, 32'h0, 32'h0100_0000, 32'h0);
    pulse_start();
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    expect_lanes("t6 reset", 32'h0, 32'h0);
    check("t6 reset busy", 64'(o_busy), 64'd0);
    check("t6 reset valid", 64'(o_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    set_uniform(32'h0080_0000, 32'h0100_0000, 32'h0, 32'h0, 32'hFF00_0000);
    pulse_start();
    wait_valid("t6", L);
    expect_lanes("t6", 32'h00C0_0000, 32'h0040_0000);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
